// File: rtl/ipml_fifo_rd_unpack_v1_0.sv
// Read-side unpacker: pops wide FIFO words and serialises them into narrow
// valid/ready beats, with a free-running packet counter driving out_last.
module ipml_fifo_rd_unpack_v1_0 #(
   parameter int unsigned c_IN_WIDTH  = 32,
   parameter int unsigned c_OUT_WIDTH = 8,
   parameter int unsigned c_MSB_FIRST = 1,
   parameter int unsigned c_PKT_BEATS = 8
) (
   input  logic                   rd_clk,
   input  logic                   rd_rst,
   input  logic [c_IN_WIDTH-1:0]  fifo_data,
   input  logic                   fifo_vld,
   output logic                   fifo_rd_en,
   output logic [c_OUT_WIDTH-1:0] out_data,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic                   out_last
);

   localparam int unsigned RATIO = c_IN_WIDTH / c_OUT_WIDTH;
   localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int unsigned PKT_W = (c_PKT_BEATS > 1) ? $clog2(c_PKT_BEATS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);
   localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(c_PKT_BEATS - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [c_IN_WIDTH-1:0]   word_q, word_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [PKT_W-1:0]        pkt_cnt_q, pkt_cnt_d;
   logic                    busy;
   logic                    last_slice;
   logic                    pop;
   logic                    xfer;
   int unsigned             shamt;

   assign busy       = (state_q == SHIFT);
   assign last_slice = (idx_q == IDX_LAST);
   assign xfer       = busy & out_rdy;

   // A pop is allowed when empty, or when the final slice leaves this cycle.
   assign fifo_rd_en = ~rd_rst & fifo_vld & (~busy | (last_slice & out_rdy));
   assign pop        = fifo_vld & fifo_rd_en;

   // Slice select: shift the active slice down to bit 0.
   always_comb begin
      shamt = 32'(idx_q) * c_OUT_WIDTH;
      if (c_MSB_FIRST != 0) begin
         shamt = (RATIO - 1 - 32'(idx_q)) * c_OUT_WIDTH;
      end
   end

   assign out_data = c_OUT_WIDTH'(word_q >> shamt);
   assign out_vld  = busy;
   assign out_last = busy & (pkt_cnt_q == PKT_LAST);

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state_q   <= IDLE;
         word_q    <= '0;
         idx_q     <= '0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         idx_q     <= idx_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      idx_d     = idx_q;
      pkt_cnt_d = pkt_cnt_q;

      // A pop only happens when idle or alongside the last-slice transfer.
      if (pop) begin
         state_d = SHIFT;
         word_d  = fifo_data;
         idx_d   = '0;
      end else if (xfer) begin
         if (last_slice) begin
            state_d = IDLE;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end

      if (xfer) begin
         pkt_cnt_d = (pkt_cnt_q == PKT_LAST) ? '0 : pkt_cnt_q + PKT_W'(1);
      end
   end

endmodule
